// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, branch flush, data-memory req/ack freeze.
// Optional DMEM_TIMEOUT_EN adds a MEM_WAIT watchdog with a sticky error state.
module pipe_stall_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_RTaddr_i,
  input  logic [4:0]  IFID_RSaddr_i,
  input  logic [4:0]  IFID_RTaddr_i,
  input  logic        Branch_taken_i,
  input  logic        EXMEM_MemAccess_i,
  input  logic        dmem_ack_i,
  output logic        dmem_req_o,
  output logic        PC_write_o,
  output logic        IFID_write_o,
  output logic        IFID_flush_o,
  output logic        IDEX_write_o,
  output logic        IDEX_bubble_o,
  output logic        EXMEM_write_o,
  output logic        MEMWB_bubble_o,
  output logic [15:0] stall_cnt_o,
  output logic        err_o
);

`ifdef DMEM_TIMEOUT_EN
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1} state_t;
`endif

  state_t      state_reg, state_next;
  logic        mem_stall;
  logic        lu_hazard;
  logic        to_expire;
  logic [15:0] stall_cnt_reg;

  assign lu_hazard = IDEX_MemRead_i && (IDEX_RTaddr_i != 5'd0) &&
                     ((IDEX_RTaddr_i == IFID_RSaddr_i) || (IDEX_RTaddr_i == IFID_RTaddr_i));

  // Request depends only on the state register so it never glitches with inputs.
  assign dmem_req_o = (state_reg == MEM_WAIT);

`ifdef DMEM_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt_reg;
  logic             err_reg;

  assign to_expire = (state_reg == MEM_WAIT) && !dmem_ack_i &&
                     (to_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (state_reg == RUN && EXMEM_MemAccess_i)
        to_cnt_reg <= '0;
      else if (state_reg == MEM_WAIT && !dmem_ack_i)
        to_cnt_reg <= to_cnt_reg + 1'b1;
      if (to_expire)
        err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`else
  // Watchdog parameters only matter with the timeout build; keep the range check visible here.
  localparam bit CFG_OK = (TIMEOUT_CYC < (1 << CNT_W));
  assign to_expire = 1'b0;
  assign err_o     = CFG_OK ? 1'b0 : 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_reg <= RUN;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    mem_stall      = 1'b0;
    PC_write_o     = 1'b1;
    IFID_write_o   = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_write_o   = 1'b1;
    IDEX_bubble_o  = 1'b0;
    EXMEM_write_o  = 1'b1;
    MEMWB_bubble_o = 1'b0;

    case (state_reg)
      RUN: begin
        if (EXMEM_MemAccess_i) begin
          state_next = MEM_WAIT;
          mem_stall  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_next = RUN;
        end else begin
          mem_stall = 1'b1;
`ifdef DMEM_TIMEOUT_EN
          if (to_expire)
            state_next = ERROR;
`endif
        end
      end
`ifdef DMEM_TIMEOUT_EN
      ERROR: begin
        mem_stall = 1'b1;
      end
`endif
      default: begin
        state_next = RUN;
      end
    endcase

    // Memory freeze dominates; a load-use bubble holds any pending branch in ID.
    if (mem_stall) begin
      PC_write_o     = 1'b0;
      IFID_write_o   = 1'b0;
      IDEX_write_o   = 1'b0;
      EXMEM_write_o  = 1'b0;
      MEMWB_bubble_o = 1'b1;
    end else if (lu_hazard) begin
      PC_write_o     = 1'b0;
      IFID_write_o   = 1'b0;
      IDEX_bubble_o  = 1'b1;
    end else if (Branch_taken_i) begin
      IFID_flush_o   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_reg <= 16'd0;
    else if (!PC_write_o && stall_cnt_reg != 16'hFFFF)
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: rule-level model checked every cycle plus directed literal checks.
module tb_pipe_stall_ctrl;
  localparam int TO = 4;
`ifdef DMEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memread, br, access, ack;
  logic [4:0]  idex_rt, rs, ifid_rt;
  logic        req, pc_w, ifid_w, flush, idex_w, idex_b, exmem_w, memwb_b, err;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .IDEX_MemRead_i(memread), .IDEX_RTaddr_i(idex_rt),
    .IFID_RSaddr_i(rs), .IFID_RTaddr_i(ifid_rt),
    .Branch_taken_i(br), .EXMEM_MemAccess_i(access), .dmem_ack_i(ack),
    .dmem_req_o(req), .PC_write_o(pc_w), .IFID_write_o(ifid_w), .IFID_flush_o(flush),
    .IDEX_write_o(idex_w), .IDEX_bubble_o(idex_b), .EXMEM_write_o(exmem_w),
    .MEMWB_bubble_o(memwb_b), .stall_cnt_o(stall_cnt), .err_o(err)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: is a memory access outstanding, has the watchdog fired, how many stalls so far.
  bit m_wait, m_err;
  int m_to, m_cnt;
  logic e_mstall, e_lu, e_pc, e_idex_w, e_memwb_b, e_idex_b, e_flush;

  always_comb begin
    e_mstall  = m_err || (m_wait ? !ack : access);
    e_lu      = memread && (idex_rt != 5'd0) && (idex_rt == rs || idex_rt == ifid_rt);
    e_pc      = !(e_mstall || e_lu);
    e_idex_w  = !e_mstall;
    e_memwb_b = e_mstall;
    e_idex_b  = !e_mstall && e_lu;
    e_flush   = !e_mstall && !e_lu && br;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 1'b0;
      m_err  <= 1'b0;
      m_to   <= 0;
      m_cnt  <= 0;
    end else begin
      if (!e_pc && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (m_err) begin
      end else if (!m_wait) begin
        if (access) begin
          m_wait <= 1'b1;
          m_to   <= 0;
        end
      end else if (ack) begin
        m_wait <= 1'b0;
      end else if (TO_EN && m_to + 1 == TO) begin
        m_wait <= 1'b0;
        m_err  <= 1'b1;
      end else begin
        m_to <= m_to + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req",       {15'd0, req},     {15'd0, m_wait});
      chk("pc_write",  {15'd0, pc_w},    {15'd0, e_pc});
      chk("ifid_write",{15'd0, ifid_w},  {15'd0, e_pc});
      chk("ifid_flush",{15'd0, flush},   {15'd0, e_flush});
      chk("idex_write",{15'd0, idex_w},  {15'd0, e_idex_w});
      chk("idex_bub",  {15'd0, idex_b},  {15'd0, e_idex_b});
      chk("exmem_wr",  {15'd0, exmem_w}, {15'd0, e_idex_w});
      chk("memwb_bub", {15'd0, memwb_b}, {15'd0, e_memwb_b});
      chk("stall_cnt", stall_cnt,        m_cnt[15:0]);
      chk("err",       {15'd0, err},     {15'd0, m_err});
    end
  end

  task automatic idle();
    memread = 0; br = 0; access = 0; ack = 0;
    idex_rt = 0; rs = 0; ifid_rt = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state with idle inputs
    @(negedge clk);
    chk("rst_pc", {15'd0, pc_w}, 16'd1);
    chk("rst_exmem", {15'd0, exmem_w}, 16'd1);
    chk("rst_req", {15'd0, req}, 16'd0);
    chk("rst_cnt", stall_cnt, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    next();

    // Load-use on rs
    memread = 1; idex_rt = 5; rs = 5;
    @(negedge clk);
    chk("lu_rs_pc", {15'd0, pc_w}, 16'd0);
    chk("lu_rs_bub", {15'd0, idex_b}, 16'd1);
    next();
    idle();
    @(negedge clk);
    chk("lu_rs_cnt", stall_cnt, 16'd1);
    next();

    // Destination r0 never hazards
    memread = 1; idex_rt = 0; rs = 0; ifid_rt = 0;
    @(negedge clk);
    chk("lu_r0_pc", {15'd0, pc_w}, 16'd1);
    next();

    // Load-use on rt with a taken branch held
    memread = 1; idex_rt = 7; rs = 3; ifid_rt = 7; br = 1;
    @(negedge clk);
    chk("lu_br_flush", {15'd0, flush}, 16'd0);
    chk("lu_br_bub", {15'd0, idex_b}, 16'd1);
    next();

    // Plain taken branch
    idle(); br = 1;
    @(negedge clk);
    chk("br_flush", {15'd0, flush}, 16'd1);
    chk("br_pc", {15'd0, pc_w}, 16'd1);
    next();

    // Memory access: detect, three waits, ack
    idle(); access = 1;
    @(negedge clk);
    chk("mem_det_req", {15'd0, req}, 16'd0);
    chk("mem_det_bub", {15'd0, memwb_b}, 16'd1);
    next();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin memread = 1; idex_rt = 5; rs = 5; br = 1; end
      @(negedge clk);
      chk("mem_wait_req", {15'd0, req}, 16'd1);
      chk("mem_wait_flush", {15'd0, flush}, 16'd0);
      chk("mem_wait_ibub", {15'd0, idex_b}, 16'd0);
      next();
      memread = 0; idex_rt = 0; rs = 0; br = 0;
    end
    ack = 1;
    @(negedge clk);
    chk("mem_ack_pc", {15'd0, pc_w}, 16'd1);
    chk("mem_ack_exmem", {15'd0, exmem_w}, 16'd1);
    next();
    idle();
    @(negedge clk);
    chk("mem_cnt", stall_cnt, 16'd6);
    chk("mem_after_req", {15'd0, req}, 16'd0);
    next();

    // Back-to-back accesses, ack in first request cycle
    access = 1; next();
    ack = 1;
    @(negedge clk);
    chk("b2b_ack_pc", {15'd0, pc_w}, 16'd1);
    next();
    ack = 0;
    @(negedge clk);
    chk("b2b_gap_req", {15'd0, req}, 16'd0);
    next();
    @(negedge clk);
    chk("b2b_req2", {15'd0, req}, 16'd1);
    ack = 1; next();
    idle();

    // Stray ack in RUN is ignored
    ack = 1;
    @(negedge clk);
    chk("stray_ack_pc", {15'd0, pc_w}, 16'd1);
    next();
    idle();

    // Asynchronous reset during MEM_WAIT with a pending ack
    access = 1; next();
    @(negedge clk);
    ack = 1;
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {15'd0, req}, 16'd0);
    chk("arst_cnt", stall_cnt, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    @(negedge clk);
    chk("arst_pc", {15'd0, pc_w}, 16'd1);
    next();

`ifdef DMEM_TIMEOUT_EN
    access = 1; next();
    repeat (TO) next();
    @(negedge clk);
    chk("to_err", {15'd0, err}, 16'd1);
    chk("to_req", {15'd0, req}, 16'd0);
    access = 0; ack = 1;
    next();
    @(negedge clk);
    chk("to_frozen", {15'd0, pc_w}, 16'd0);
    rst = 1'b1; #1 rst = 1'b0;
    idle();
    next();
`endif

    repeat (2) next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush scheduler for the 5-stage pipeline. It owns the write-enable, bubble and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, flushes on taken branches, and runs a req/ack handshake with a multi-cycle data memory, freezing the pipeline while the MEM stage waits.

## Interface
Parameters:
- TIMEOUT_CYC, 255: MEM_WAIT cycles before the watchdog fires. Used only with DMEM_TIMEOUT_EN.
- CNT_W, 8: watchdog counter width. Must satisfy TIMEOUT_CYC < 2^CNT_W.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- IDEX_MemRead_i  in  1  load instruction is in EX.
- IDEX_RTaddr_i  in  5  destination register of that load.
- IFID_RSaddr_i  in  5  rs of the instruction in ID.
- IFID_RTaddr_i  in  5  rt of the instruction in ID.
- Branch_taken_i  in  1  branch resolved taken in ID.
- EXMEM_MemAccess_i  in  1  load or store is in MEM.
- dmem_ack_i  in  1  data memory completes the access.
- dmem_req_o  out  1  data memory request.
- PC_write_o  out  1  PC load enable.
- IFID_write_o  out  1  IF/ID load enable.
- IFID_flush_o  out  1  IF/ID loads a NOP.
- IDEX_write_o  out  1  ID/EX load enable.
- IDEX_bubble_o  out  1  ID/EX loads zeroed control.
- EXMEM_write_o  out  1  EX/MEM load enable.
- MEMWB_bubble_o  out  1  MEM/WB loads WB=2'b00.
- stall_cnt_o  out  16  count of cycles with PC_write_o=0.
- err_o  out  1  sticky watchdog error.

## Operation
- State machine with states RUN, MEM_WAIT and ERROR. ERROR exists only with DMEM_TIMEOUT_EN.
- RUN:
  - If EXMEM_MemAccess_i=1, go to MEM_WAIT. This cycle counts as a memory stall.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - dmem_req_o=1.
  - If dmem_ack_i=1, go to RUN. The pipeline advances on this edge.
  - Otherwise stay in MEM_WAIT.
- dmem_ack_i is ignored outside MEM_WAIT.
- mem_stall = (state==RUN && EXMEM_MemAccess_i) || (state==MEM_WAIT && !dmem_ack_i) || state==ERROR.
- lu_hazard = IDEX_MemRead_i && IDEX_RTaddr_i!=0 && (IDEX_RTaddr_i==IFID_RSaddr_i || IDEX_RTaddr_i==IFID_RTaddr_i).
- Priority is mem_stall, then lu_hazard, then branch flush.
- When mem_stall=1:
  - PC_write_o, IFID_write_o, IDEX_write_o and EXMEM_write_o are 0.
  - MEMWB_bubble_o=1.
  - IDEX_bubble_o=0 and IFID_flush_o=0.
- When lu_hazard=1 and mem_stall=0:
  - PC_write_o=0 and IFID_write_o=0.
  - IDEX_bubble_o=1.
  - IDEX_write_o=1 and EXMEM_write_o=1.
  - IFID_flush_o=0, because the branch is held.
- When Branch_taken_i=1 and there is no stall: IFID_flush_o=1.
- Default, with no stall and no flush: every write output is 1, every bubble/flush output is 0, and dmem_req_o=0.
- stall_cnt_o adds 1 on each edge where PC_write_o=0. It saturates at 16'hFFFF and does not wrap.

## Timing
- All control outputs are combinational from the state register and the current inputs, so they are valid in the same cycle.
- dmem_req_o is decoded from state alone and is glitch-free.
- Minimum memory-access occupancy of the MEM stage is 2 cycles:
  - Detect cycle in RUN.
  - One MEM_WAIT cycle with dmem_ack_i=1.
  - Each extra cycle without ack adds 1 stall cycle.
- An ack in the same cycle as the first dmem_req_o is legal.
- Back-to-back memory instructions: after the ack edge the next instruction in MEM is seen in RUN, and a new request starts one cycle later. dmem_req_o drops for exactly one cycle in between.
- Reset values:
  - State RUN, dmem_req_o=0, stall_cnt_o=0, err_o=0.
  - With idle inputs, all write enables are 1.
- Reset asserted during MEM_WAIT or ERROR returns to RUN asynchronously and drops dmem_req_o immediately. A pending ack is discarded.

## Configuration
- DMEM_TIMEOUT_EN defined:
  - A CNT_W-bit counter clears on entry to MEM_WAIT and adds 1 on each MEM_WAIT cycle without an ack.
  - When the counter reaches TIMEOUT_CYC, the state goes to ERROR and err_o=1.
  - In ERROR, dmem_req_o=0 and the pipeline stays frozen until rst_i.
- DMEM_TIMEOUT_EN not defined:
  - No counter and no ERROR state.
  - err_o is tied to 0.
  - MEM_WAIT waits indefinitely.

## Test plan
- Reset, then idle inputs -> all write enables 1, bubbles/flush 0, dmem_req_o=0, stall_cnt_o=0.
- IDEX_MemRead_i=1, IDEX_RTaddr_i=5, IFID_RSaddr_i=5 for 1 cycle -> PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, stall_cnt_o=1. Repeating with RTaddr=0 gives no stall.
- EXMEM_MemAccess_i=1, ack 3 cycles after req rises -> 4 frozen cycles, MEMWB_bubble_o=1 during the wait, write enables 1 in the ack cycle, stall_cnt_o=4.
- Load-use hazard and Branch_taken_i=1 during a memory stall -> only the mem-stall pattern appears. IFID_flush_o=0 and IDEX_bubble_o=0.
- rst_i pulsed mid MEM_WAIT -> dmem_req_o falls before the next edge, state is RUN, stall_cnt_o=0.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYC=4, no ack -> err_o=1 after 4 MEM_WAIT cycles, dmem_req_o=0, frozen until reset.
